uart_tx: RTL

Serial UART transmitter. It is the transmit-side counterpart to the existing UART receiver in the RSA datapath, and sends ciphertext/plaintext bytes back to the host.
- Accepts one payload word per valid/ready handshake.
- Serialises the word LSB first: start bit, payload, optional parity, then stop bit(s), on uart_txd.
- Uses the same bit-timing arithmetic as the receiver, so both ends agree on the baud rate.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver: FSM state
// encoding and the bit-timing arithmetic both ends must agree on.
package uart_pkg;

    // 3-bit state encoding shared with the receiver
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    // Clock cycles per serial bit (integer division, same as the receiver)
    function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                   input int unsigned bit_rate);
        return clk_hz / bit_rate;
    endfunction

    // Width of the per-bit cycle counter
    function automatic int unsigned count_width(input int unsigned cpb);
        return 32'(1 + $clog2(cpb));
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clk cycles and pulses bit_done on the last cycle
// of each bit period, then wraps to 0 so every bit is exactly bit_cycles long.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   restart      - hold the counter at 0 (asserted by the owner between frames)
//   bit_cycles   - bit period length in clk cycles
//   bit_done     - high on the final cycle of the current bit period
module uart_bit_timer #(
    parameter int unsigned COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    input  logic [COUNT_W-1:0] bit_cycles,
    output logic               bit_done
);

    logic [COUNT_W-1:0] count;

    assign bit_done = !restart && (count == bit_cycles - COUNT_W'(1));

    // Wrapping on bit_done restarts each bit at 0, so no drift accumulates
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count <= '0;
        end else if (bit_done) begin
            count <= '0;
        end else begin
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word per valid/ready handshake and sends it
// LSB first as start bit, payload, optional even parity, stop bit(s).
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   uart_tx_en     - enable; no new frame is accepted while low
//   uart_tx_valid  - uart_tx_data holds a word to send
//   uart_tx_data   - payload word
//   uart_tx_ready  - word can be accepted this cycle (combinational)
//   uart_tx_busy   - a frame is on the line (combinational)
//   uart_txd       - registered serial line, idles high
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned BIT_RATE     = 9600,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_tx_en,
    input  logic                    uart_tx_valid,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_ready,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int unsigned COUNT_W        = count_width(CYCLES_PER_BIT);
    localparam int unsigned BIT_CNT_W      = $clog2(PAYLOAD_BITS + 1);

    uart_state_e             state;
    logic [PAYLOAD_BITS-1:0] shift;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic                    bit_done;
    logic                    accept;
    logic                    timer_restart;
`ifdef UART_TX_PARITY_EN
    logic                    parity;
`endif

    assign uart_tx_ready = (state == IDLE) && uart_tx_en && !reset;
    assign uart_tx_busy  = (state != IDLE);
    assign accept        = uart_tx_valid && uart_tx_ready;

    // Timer held at 0 while idle, so the start bit begins a fresh period
    assign timer_restart = (state == IDLE);

    uart_bit_timer #(
        .COUNT_W (COUNT_W)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .restart    (timer_restart),
        .bit_cycles (COUNT_W'(CYCLES_PER_BIT)),
        .bit_done   (bit_done)
    );

    // Frame FSM; uart_txd is loaded with the value of the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            uart_txd <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (accept) begin
                        state    <= START;
                        shift    <= uart_tx_data;
                        bit_cnt  <= '0;
                        uart_txd <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity   <= ^uart_tx_data;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state    <= DATA;
                        uart_txd <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift <= shift >> 1;
                        if (bit_cnt == BIT_CNT_W'(PAYLOAD_BITS - 1)) begin
                            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= parity;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                            // shift[1] becomes shift[0] on this same edge
                            uart_txd <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    // bit_cnt reused to count stop bits
                    if (bit_done) begin
                        if (bit_cnt == BIT_CNT_W'(STOP_BITS - 1)) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule
